alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU select code together with the two operands and the writeback tag.
- Computes the ALU result and zero flag, then registers them into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Feeds the memory/writeback stage and provides full throughput under back-pressure.

Parameters:
WIDTH, 32, operand/result width in bits
RDW, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an operation
in_ready  out  1  stage can accept an operation this cycle
alusel  in  4  ALU select: 0010 add, 0110 sub, 0000 and, 0001 or
a  in  WIDTH  operand A
b  in  WIDTH  operand B
rd  in  RDW  destination register index
regwrite  in  1  writeback enable tag
flush  in  1  synchronous kill of all held operations
out_valid  out  1  result entry valid
out_ready  in  1  downstream accepts entry
result  out  WIDTH  ALU result
zero  out  1  result == 0
rd_out  out  RDW  passed-through rd
regwrite_out  out  1  passed-through regwrite
illegal  out  1  alusel was not one of the four defined codes
occ  out  2  entries held (0..2)

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0, result=0, zero=0, rd_out=0, regwrite_out=0, illegal=0, occ=0, in_ready=1. Skid contents cleared.
- ALU (combinational, evaluated on input side):
  - add = a+b mod 2^WIDTH; sub = a-b mod 2^WIDTH (two's complement, no carry/overflow outputs); and = a&b; or = a|b.
  - Any other alusel: result=0, illegal=1, zero=1.
  - zero = (result == 0).
- Entry: {result, zero, rd, regwrite, illegal}, captured at the clock edge where in_valid & in_ready (in_fire).
- Latency: 1 cycle from in_fire to out_valid with that entry at the head. Entries leave in acceptance order.
- out_fire = out_valid & out_ready.
- in_ready = (state != FULL). It depends on state only, never combinationally on out_ready.
- State machine (main = head entry, skid = second entry):
  - EMPTY (occ=0): in_fire -> BUSY, main<=new.
  - BUSY (occ=1):
    - in_fire & out_fire -> BUSY, main<=new.
    - in_fire & !out_fire -> FULL, skid<=new.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL (occ=2): in_ready=0. out_fire -> BUSY, main<=skid. Otherwise hold.
- Output stability: while out_valid=1 and out_ready=0, all output fields remain constant.
- Flush (synchronous, highest priority):
  - Next state EMPTY, occ=0, out_valid=0.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by downstream.
- Payload on out_valid=0: output payload fields hold their last value and carry no meaning.
- Reset mid-operation: all entries are dropped immediately, asynchronously.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Reset then single op: alusel=0010, a=5, b=7, rd=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, rd_out=3, regwrite_out=1; following cycle out_valid=0, occ=0.
- Sub/zero and wrap: alusel=0110, a=9, b=9 -> result=0, zero=1. Then a=0, b=1 -> result=0xFFFFFFFF, zero=0. Then alusel=0010, a=0xFFFFFFFF, b=1 -> result=0, zero=1.
- Back-pressure: out_ready=0, issue add(1,1) then or(0xF0,0x0F) -> occ=2, in_ready=0, result=2 held. Raise out_ready -> result=2, then 0xFF next cycle, in_ready=1 after first pop.
- Full throughput: out_ready=1, in_valid=1 for 8 back-to-back and(a=i, b=0xFF) ops -> 8 consecutive out_valid cycles, results 0..7 in order, in_ready never drops.
- Illegal code: alusel=1111, a=3, b=4 -> result=0, illegal=1, zero=1. Next op add(3,4) -> illegal=0, result=7.
- Flush and async reset: fill to occ=2, then assert flush with in_valid=1 -> next cycle occ=0, out_valid=0, new op not captured. Refill, then drop rst_n mid-cycle -> out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: ALU execute stage feeding a 2-entry skid buffer with valid/ready on both sides
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RDW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alusel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RDW-1:0]   rd,
  input  logic             regwrite,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [RDW-1:0]   rd_out,
  output logic             regwrite_out,
  output logic             illegal,
  output logic [1:0]       occ
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [RDW-1:0]   rd;
    logic             rw;
    logic             ill;
  } entry_t;
  state_t state;
  entry_t main_e, skid_e, new_e;
  logic [WIDTH-1:0] res;
  logic in_fire, out_fire;
  assign in_ready = state != FULL;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign result = main_e.result;
  assign zero = main_e.zero;
  assign rd_out = main_e.rd;
  assign regwrite_out = main_e.rw;
  assign illegal = main_e.ill;
  always_comb begin
    res = alusel == 4'b0010 ? a + b :
          alusel == 4'b0110 ? a - b :
          alusel == 4'b0000 ? a & b :
          alusel == 4'b0001 ? a | b : '0;
    new_e = {res, res == '0, rd, regwrite, !(alusel inside {4'b0010, 4'b0110, 4'b0000, 4'b0001})};
  end
  // main is the head entry driving the outputs; skid holds the entry accepted while main was stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      occ <= 2'd0;
      main_e <= '0;
      skid_e <= '0;
    end else if (flush) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      occ <= 2'd0;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          main_e <= new_e;
          state <= BUSY;
          out_valid <= 1'b1;
          occ <= 2'd1;
        end
        BUSY: if (in_fire && out_fire) main_e <= new_e;
        else if (in_fire) begin
          skid_e <= new_e;
          state <= FULL;
          occ <= 2'd2;
        end else if (out_fire) begin
          state <= EMPTY;
          out_valid <= 1'b0;
          occ <= 2'd0;
        end
        FULL: if (out_fire) begin
          main_e <= skid_e;
          state <= BUSY;
          occ <= 2'd1;
        end
        default: begin
          state <= EMPTY;
          out_valid <= 1'b0;
          occ <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: table-driven vectors and scoreboard for alu_ex_stage
module tb_alu_ex_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [3:0] alusel = '0;
  logic [31:0] a = '0, b = '0, result;
  logic [4:0] rd = '0, rd_out;
  logic regwrite = 1'b0, out_valid, out_ready = 1'b0, zero, regwrite_out, illegal;
  logic [1:0] occ;

  alu_ex_stage #(.WIDTH(32), .RDW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alusel(alusel), .a(a), .b(b), .rd(rd), .regwrite(regwrite), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .rd_out(rd_out), .regwrite_out(regwrite_out), .illegal(illegal), .occ(occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] r;
    logic        z, il;
  } vec_t;

  int n_vec = 0, n_fail = 0, pops = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_cur = '0;
  logic hold_prev = 1'b0;
  logic [40:0] prev_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: pop on out_fire, push on in_fire, drop everything on flush/reset
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", {23'd0, out_valid, result, zero, rd_out, regwrite_out, illegal}, {23'd0, prev_out});
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else check("sb_entry", {24'd0, result, zero, rd_out, regwrite_out, illegal}, {24'd0, sb.pop_front()});
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(exp_cur);
      hold_prev <= out_valid && !out_ready && !flush;
      prev_out <= {out_valid, result, zero, rd_out, regwrite_out, illegal};
    end
  end

  int stalls = 0;

  task automatic send(input vec_t v);
    int n;
    n = 0;
    in_valid = 1'b1;
    alusel = v.sel; a = v.a; b = v.b; rd = v.rd; regwrite = v.rw;
    exp_cur = {v.r, v.z, v.rd, v.rw, v.il};
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                              input logic [4:0] r, input logic w, input logic [31:0] e,
                              input logic z, input logic il);
    vec_t v;
    v.sel = s; v.a = x; v.b = y; v.rd = r; v.rw = w; v.r = e; v.z = z; v.il = il;
    return v;
  endfunction

  vec_t tbl[8];
  int p0, n;

  initial begin
    tbl[0] = mk(4'b0110, 32'd9, 32'd9, 5'd1, 1'b1, 32'd0, 1'b1, 1'b0);
    tbl[1] = mk(4'b0110, 32'd0, 32'd1, 5'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tbl[2] = mk(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd31, 1'b1, 32'd0, 1'b1, 1'b0);
    tbl[3] = mk(4'b1111, 32'd3, 32'd4, 5'd4, 1'b1, 32'd0, 1'b1, 1'b1);
    tbl[4] = mk(4'b0010, 32'd3, 32'd4, 5'd5, 1'b0, 32'd7, 1'b0, 1'b0);
    tbl[5] = mk(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 1'b1, 32'h00F0_1200, 1'b0, 1'b0);
    tbl[6] = mk(4'b0001, 32'hA000_0001, 32'h0500_0010, 5'd7, 1'b1, 32'hA500_0011, 1'b0, 1'b0);
    tbl[7] = mk(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0, 32'd0, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_payload", {24'd0, result, zero, rd_out, regwrite_out, illegal}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    out_ready = 1'b1;
    send(mk(4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b0, 1'b0));
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_result", 64'(result), 64'd12);
    idle(1);
    check("single_drain_valid", 64'(out_valid), 64'd0);
    check("single_drain_occ", 64'(occ), 64'd0);

    for (int i = 0; i < 8; i++) send(tbl[i]);
    idle(2);

    out_ready = 1'b0;
    send(mk(4'b0010, 32'd1, 32'd1, 5'd9, 1'b1, 32'd2, 1'b0, 1'b0));
    send(mk(4'b0001, 32'hF0, 32'h0F, 5'd10, 1'b0, 32'hFF, 1'b0, 1'b0));
    check("bp_occ", 64'(occ), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_result", 64'(result), 64'd2);
    idle(2);
    check("bp_held_result", 64'(result), 64'd2);
    out_ready = 1'b1;
    idle(1);
    check("bp_pop1_result", 64'(result), 64'hFF);
    check("bp_pop1_in_ready", 64'(in_ready), 64'd1);
    check("bp_pop1_occ", 64'(occ), 64'd1);
    idle(1);
    check("bp_empty_occ", 64'(occ), 64'd0);

    p0 = pops;
    stalls = 0;
    for (int i = 0; i < 8; i++)
      send(mk(4'b0000, 32'(i), 32'hFF, 5'(i), 1'b1, 32'(i), i == 0, 1'b0));
    idle(2);
    check("tput_pops", 64'(pops - p0), 64'd8);
    check("tput_stalls", 64'(stalls), 64'd0);

    out_ready = 1'b0;
    send(mk(4'b0010, 32'd10, 32'd20, 5'd11, 1'b1, 32'd30, 1'b0, 1'b0));
    in_valid = 1'b1; flush = 1'b1; alusel = 4'b0010; a = 32'd1; b = 32'd2;
    idle(1);
    in_valid = 1'b0; flush = 1'b0;
    check("flush1_occ", 64'(occ), 64'd0);
    check("flush1_valid", 64'(out_valid), 64'd0);
    idle(2);
    check("flush1_not_captured", 64'(out_valid), 64'd0);

    send(mk(4'b0110, 32'd50, 32'd8, 5'd12, 1'b1, 32'd42, 1'b0, 1'b0));
    send(mk(4'b0001, 32'd1, 32'd2, 5'd13, 1'b0, 32'd3, 1'b0, 1'b0));
    check("flush2_pre_occ", 64'(occ), 64'd2);
    in_valid = 1'b1; flush = 1'b1;
    idle(1);
    in_valid = 1'b0; flush = 1'b0;
    check("flush2_occ", 64'(occ), 64'd0);
    check("flush2_valid", 64'(out_valid), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);

    send(mk(4'b0010, 32'd100, 32'd1, 5'd14, 1'b1, 32'd101, 1'b0, 1'b0));
    send(mk(4'b0010, 32'd200, 32'd2, 5'd15, 1'b1, 32'd202, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_occ", 64'(occ), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    send(mk(4'b0110, 32'd7, 32'd2, 5'd16, 1'b1, 32'd5, 1'b0, 1'b0));
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
